instr_encoder: RTL and testbench

- Pipelined RISC-V instruction encoder. It does the reverse of the immediate-extend stage: it takes decoded fields plus a 32-bit immediate and an `imm_src` format code, and packs them into a 32-bit instruction word.
- Used by the instruction-memory loader and by self-test logic to stream encoded words, with word addresses, into instruction memory.
- Checks that each immediate fits and is aligned for its format. Failing requests are replaced by a NOP.
- Valid/ready handshake on both sides, 2-stage pipeline, throughput of 1 word per clock.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/imm_scatter.sv | 35 +++
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: immediate formats, opcodes, NOP word and
// the request record carried through the encoder's first stage.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [1:0]  imm_src;
    } enc_req_t;

endpackage

// File: rtl/imm_scatter.sv
// Scatters a signed immediate into its instruction bit positions for the given
// format, and flags immediates that do not fit or are misaligned.
module imm_scatter
    import riscv_pkg::*;
(
    input  logic [31:0] imm_i,
    input  logic [1:0]  imm_src_i,
    output logic [31:0] imm_bits_o,
    output logic        range_err_o
);

    always_comb begin
        imm_bits_o  = '0;
        range_err_o = 1'b0;
        case (imm_src_e'(imm_src_i))
            IMM_I: begin
                imm_bits_o  = {imm_i[11:0], 20'b0};
                range_err_o = !(&imm_i[31:11] || ~|imm_i[31:11]);
            end
            IMM_S: begin
                imm_bits_o  = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
                range_err_o = !(&imm_i[31:11] || ~|imm_i[31:11]);
            end
            IMM_B: begin
                imm_bits_o  = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
                range_err_o = !(&imm_i[31:12] || ~|imm_i[31:12]) || imm_i[0];
            end
            default: begin
                imm_bits_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
                range_err_o = !(&imm_i[31:20] || ~|imm_i[31:20]) || imm_i[0];
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RISC-V instruction encoder: S1 holds the request and
// packs it combinationally, S2 is the output register with address/error count.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    input  logic [1:0]       in_imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             out_err,
    output logic [ERR_W-1:0] err_count
);

    logic             en_q;
    logic             s1_vld_q, s1_vld_d;
    enc_req_t         s1_q, s1_d;
    logic             s2_vld_q, s2_vld_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      addr_q, addr_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic        accept, deliver, s2_load;
    logic [31:0] imm_bits, fields, enc_word;
    logic        range_err;

    assign deliver  = s2_vld_q && out_ready;
    assign s2_load  = s1_vld_q && (!s2_vld_q || out_ready);
    // en_q keeps in_ready low until the first edge after reset release
    assign in_ready = en_q && (!s1_vld_q || s2_load);
    assign accept   = in_valid && in_ready;

    imm_scatter u_scatter (
        .imm_i      (s1_q.imm),
        .imm_src_i  (s1_q.imm_src),
        .imm_bits_o (imm_bits),
        .range_err_o(range_err)
    );

    always_comb begin
        fields = {25'b0, s1_q.opcode};
        case (imm_src_e'(s1_q.imm_src))
            IMM_I:   fields = {12'b0, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
            IMM_S,
            IMM_B:   fields = {7'b0, s1_q.rs2, s1_q.rs1, s1_q.funct3, 5'b0, s1_q.opcode};
            default: fields = {20'b0, s1_q.rd, s1_q.opcode};
        endcase
        enc_word = range_err ? NOP_INSTR : (fields | imm_bits);
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        if (s2_load) s1_vld_d = 1'b0;
        if (accept) begin
            s1_vld_d       = 1'b1;
            s1_d.opcode    = in_opcode;
            s1_d.rd        = in_rd;
            s1_d.funct3    = in_funct3;
            s1_d.rs1       = in_rs1;
            s1_d.rs2       = in_rs2;
            s1_d.imm       = in_imm;
            s1_d.imm_src   = in_imm_src;
        end
    end

    always_comb begin
        s2_vld_d = s2_vld_q;
        instr_d  = instr_q;
        err_d    = err_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        if (deliver) begin
            s2_vld_d = 1'b0;
            addr_d   = addr_q + 32'd4;
            if (err_q && cnt_q != '1) cnt_d = cnt_q + ERR_W'(1);
        end
        if (s2_load) begin
            s2_vld_d = 1'b1;
            instr_d  = enc_word;
            err_d    = range_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            instr_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= BASE_ADDR;
            cnt_q    <= '0;
        end else begin
            en_q     <= 1'b1;
            s1_vld_q <= s1_vld_d;
            s1_q     <= s1_d;
            s2_vld_q <= s2_vld_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign out_err   = err_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against an in-order
// scoreboard built from the RISC-V field layouts and the extend-stage decode.
module tb_instr_encoder;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic [1:0]  in_imm_src;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0), .ERR_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_imm_src(in_imm_src),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  src;
        logic [31:0] imm;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0;
    logic [31:0] m_addr = 32'h0;
    int          m_errs = 0;
    int          n_dlv = 0;
    logic        last_acc;

    logic        r_valid = 1'b0, r_ordy = 1'b1;
    logic [6:0]  r_op = '0;
    logic [4:0]  r_rd = '0, r_rs1 = '0, r_rs2 = '0;
    logic [2:0]  r_f3 = '0;
    logic [31:0] r_imm = '0;
    logic [1:0]  r_src = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit fits(input logic [1:0] s, input logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (s)
            2'd0, 2'd1: return v >= -2048 && v <= 2047;
            2'd2:       return v >= -4096 && v <= 4095 && imm[0] == 1'b0;
            default:    return v >= -(1 << 20) && v < (1 << 20) && imm[0] == 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm,
                                        input logic [1:0] s);
        if (!fits(s, imm)) return 32'h0000_0013;
        case (s)
            2'd0:    return {imm[11:0], rs1, f3, rd, op};
            2'd1:    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            2'd2:    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            default: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        endcase
    endfunction

    // extend stage: recover the immediate from an encoded word
    function automatic logic [31:0] dec(input logic [31:0] w, input logic [1:0] s);
        case (s)
            2'd0:    return {{20{w[31]}}, w[31:20]};
            2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    task automatic tick();
        exp_t e;
        logic acc, dlv;
        in_valid = r_valid; in_opcode = r_op; in_rd = r_rd; in_funct3 = r_f3;
        in_rs1 = r_rs1; in_rs2 = r_rs2; in_imm = r_imm; in_imm_src = r_src;
        out_ready = r_ordy;
        @(negedge clk);
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        if (dlv) begin
            chk("unexpected_word", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("instr", out_instr, e.instr);
                chk("err", 32'(out_err), 32'(e.err));
                chk("addr", out_addr, m_addr);
                chk("err_count", 32'(err_count), 32'(m_errs));
                if (!e.err) chk("round_trip", dec(out_instr, e.src), e.imm);
                m_addr = m_addr + 32'd4;
                if (e.err && m_errs < 255) m_errs++;
            end
            n_dlv++;
        end
        if (acc) begin
            e.instr = enc(r_op, r_rd, r_f3, r_rs1, r_rs2, r_imm, r_src);
            e.err   = !fits(r_src, r_imm);
            e.src   = r_src;
            e.imm   = r_imm;
            q.push_back(e);
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic [1:0] s);
        r_op = op; r_rd = rd; r_f3 = f3; r_rs1 = rs1; r_rs2 = rs2; r_imm = imm; r_src = s;
        r_valid = 1'b1;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [1:0] s);
        bit ok;
        ok = 0;
        set_req(op, rd, f3, rs1, rs2, imm, s);
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = last_acc;
        end
        r_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        r_valid = 1'b0;
        r_ordy  = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) tick();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] snap_i, snap_a;
        logic        snap_e, have_snap;
        int          idx, d0, legal, acc_n, pend;
        logic [31:0] bp_imm[4];

        reset = 1'b1;
        in_valid = 0; in_opcode = 0; in_rd = 0; in_funct3 = 0; in_rs1 = 0;
        in_rs2 = 0; in_imm = 0; in_imm_src = 0; out_ready = 1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // addi x1,x0,5 with latency check
        send(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, IMM_I);
        chk("lat_s1_only", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("addi_word", out_instr, 32'h0050_0093);
        chk("addi_addr", out_addr, 32'd0);
        drain();

        // back-to-back stream
        d0 = n_dlv;
        set_req(OP_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 32'd8, IMM_S);
        tick(); chk("b2b_acc0", 32'(last_acc), 32'd1);
        q[q.size()-1].instr = 32'h0020_A423;
        set_req(OP_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, -32'sd4, IMM_B);
        tick(); chk("b2b_acc1", 32'(last_acc), 32'd1);
        q[q.size()-1].instr = 32'hFE00_0EE3;
        set_req(OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 32'd8, IMM_J);
        tick(); chk("b2b_acc2", 32'(last_acc), 32'd1);
        q[q.size()-1].instr = 32'h0080_00EF;
        r_valid = 1'b0;
        tick(); tick();
        chk("b2b_rate", 32'(n_dlv - d0), 32'd3);
        drain();

        // range/alignment errors
        send(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, IMM_I);
        send(OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3, IMM_B);
        drain();
        chk("err_count_2", 32'(err_count), 32'd2);
        chk("err_addr_adv", out_addr, 32'd24);

        // backpressure
        bp_imm = '{32'd1, 32'd2, 32'd3, 32'd4};
        d0 = n_dlv; idx = 0; have_snap = 0; snap_i = '0; snap_a = '0; snap_e = 0;
        r_ordy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 4) set_req(OP_IMM, 5'd3, 3'd0, 5'd4, 5'd0, bp_imm[idx], IMM_I);
            else r_valid = 1'b0;
            tick();
            if (last_acc) idx++;
            if (out_valid) begin
                if (!have_snap) begin
                    snap_i = out_instr; snap_a = out_addr; snap_e = out_err; have_snap = 1;
                end else begin
                    chk("bp_hold_instr", out_instr, snap_i);
                    chk("bp_hold_addr", out_addr, snap_a);
                    chk("bp_hold_err", 32'(out_err), 32'(snap_e));
                end
            end
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        r_ordy = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            set_req(OP_IMM, 5'd3, 3'd0, 5'd4, 5'd0, bp_imm[idx], IMM_I);
            tick();
            if (last_acc) idx++;
        end
        drain();
        chk("bp_delivered", 32'(n_dlv - d0), 32'd4);

        // asynchronous reset with two words in flight
        r_ordy = 1'b0;
        send(OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 32'd7, IMM_I);
        send(OP_IMM, 5'd6, 3'd0, 5'd0, 5'd0, 32'd9, IMM_I);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr", out_addr, 32'd0);
        chk("mid_rst_errcnt", 32'(err_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        q.delete(); m_addr = 32'h0; m_errs = 0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        r_ordy = 1'b1;
        send(OP_IMM, 5'd7, 3'd1, 5'd2, 5'd0, 32'd11, IMM_I);
        chk("post_rst_addr", out_addr, 32'd0);
        drain();

        // randomized stream, mostly legal
        legal = 0; pend = 0;
        for (int c = 0; c < 20000 && legal < 1000; c++) begin
            if (!pend && $urandom_range(0, 4) != 0) begin
                logic [1:0]  s;
                logic [31:0] imm;
                int          v;
                s = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) imm = $urandom();
                else begin
                    case (s)
                        2'd0, 2'd1: v = int'($urandom_range(0, 4095)) - 2048;
                        2'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
                        default:    v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
                    endcase
                    imm = v;
                end
                set_req(7'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()),
                        5'($urandom()), imm, s);
                pend = 1;
            end
            r_ordy = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc) begin
                if (fits(r_src, r_imm)) legal++;
                pend = 0;
                r_valid = 1'b0;
            end
        end
        chk("rand_legal_count", 32'(legal), 32'd1000);
        drain();

        // error counter saturation
        acc_n = 0;
        set_req(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'd4096, IMM_I);
        for (int c = 0; c < 400 && acc_n < 300; c++) begin
            tick();
            if (last_acc) acc_n++;
        end
        drain();
        chk("sat_errors_sent", 32'(acc_n), 32'd300);
        chk("err_count_sat", 32'(err_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
